// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : Bundle of the pipeline (P) and debug (D) request ports of
//                the shared data memory, plus the arbiter's owner status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Pipeline port
    logic              pReq;
    logic              pWrite;
    logic [ADDR_W-1:0] pAddr;
    logic [DATA_W-1:0] pWdata;
    logic              pStall;
    logic [DATA_W-1:0] pRdata;
    logic              pValid;
    // Debug / loader port
    logic              dReq;
    logic              dWrite;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dAck;
    logic [DATA_W-1:0] dRdata;
    logic              dValid;
    // Last-grant status
    logic [1:0]        owner;

    // Requester side (pipeline stage, debug loader, testbench)
    modport master (
        output pReq, pWrite, pAddr, pWdata,
        input  pStall, pRdata, pValid,
        output dReq, dWrite, dAddr, dWdata,
        input  dAck, dRdata, dValid,
        input  owner
    );

    // Arbiter side
    modport slave (
        input  pReq, pWrite, pAddr, pWdata,
        output pStall, pRdata, pValid,
        input  dReq, dWrite, dAddr, dWdata,
        output dAck, dRdata, dValid,
        output owner
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Single-port DEPTH-word data memory shared between the
//                pipeline port (priority) and the debug port (protected
//                from starvation by a saturating wait counter).
//                DEPTH must not exceed 2**ADDR_W; MAX_WAIT must be >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int MAX_WAIT = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    data_mem_arbiter_if.slave  bus
);

    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  C_MAX   = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_PIPE = 2'b01,
        OWN_DBG  = 2'b10
    } owner_t;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Power-on image: mem[i]=i below 20, then 1,2,5 at 20..22, zero above.
    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 20)       img[i] = DATA_W'(i);
            else if (i == 20) img[i] = DATA_W'(1);
            else if (i == 21) img[i] = DATA_W'(2);
            else if (i == 22) img[i] = DATA_W'(5);
            else              img[i] = '0;
        end
        return img;
    endfunction

    // Memory preload is not touched by reset; contents survive it.
    logic [DATA_W-1:0] mem_q [DEPTH] = init_image();

    logic [CNT_W-1:0]  waitCnt_q;
    logic [DATA_W-1:0] pRdata_q;
    logic              pValid_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              dValid_q;
    owner_t            owner_q;

    logic              force_d;
    logic              grant_p;
    logic              grant_d;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic [DATA_W-1:0] rd_word;

    // Same-cycle grant decision and selection of the single memory access
    always_comb begin
        force_d      = bus.dReq && (waitCnt_q == C_MAX);
        grant_p      = bus.pReq && !force_d;
        grant_d      = bus.dReq && !grant_p;
        acc_write    = grant_p ? bus.pWrite : bus.dWrite;
        acc_addr     = grant_p ? bus.pAddr  : bus.dAddr;
        acc_wdata    = grant_p ? bus.pWdata : bus.dWdata;
        acc_in_range = ({1'b0, acc_addr} < C_DEPTH);
        rd_word      = acc_in_range ? mem_q[acc_addr] : '0;
    end

    assign bus.pStall = bus.pReq && !grant_p;
    assign bus.dAck   = grant_d;
    assign bus.pRdata = pRdata_q;
    assign bus.pValid = pValid_q;
    assign bus.dRdata = dRdata_q;
    assign bus.dValid = dValid_q;
    assign bus.owner  = owner_q;

    // Granted in-range write; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (!reset && (grant_p || grant_d) && acc_write && acc_in_range) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    // Read-data capture, single-cycle valid pulses and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pRdata_q  <= '0;
            pValid_q  <= 1'b0;
            dRdata_q  <= '0;
            dValid_q  <= 1'b0;
            waitCnt_q <= '0;
        end else begin
            pValid_q <= grant_p && !bus.pWrite;
            dValid_q <= grant_d && !bus.dWrite;
            if (grant_p && !bus.pWrite) begin
                pRdata_q <= rd_word;
            end
            if (grant_d && !bus.dWrite) begin
                dRdata_q <= rd_word;
            end
            if (bus.dReq && !grant_d) begin
                if (waitCnt_q != C_MAX) begin
                    waitCnt_q <= waitCnt_q + CNT_W'(1);
                end
            end else begin
                waitCnt_q <= '0;
            end
        end
    end

    // Owner FSM: next state depends only on this cycle's grant, so the
    // unused code 2'b11 falls back to IDLE on the next idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_IDLE;
        end else if (grant_p) begin
            owner_q <= OWN_PIPE;
        end else if (grant_d) begin
            owner_q <= OWN_DBG;
        end else begin
            owner_q <= OWN_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Directed self-checking bench for data_mem_arbiter.
//                u0: default configuration; u1: DEPTH=24.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    data_mem_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    data_mem_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .MAX_WAIT(3)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .MAX_WAIT(3)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.pReq = 0; bus0.pWrite = 0; bus0.pAddr = '0; bus0.pWdata = '0;
        bus0.dReq = 0; bus0.dWrite = 0; bus0.dAddr = '0; bus0.dWdata = '0;
        bus1.pReq = 0; bus1.pWrite = 0; bus1.pAddr = '0; bus1.pWdata = '0;
        bus1.dReq = 0; bus1.dWrite = 0; bus1.dAddr = '0; bus1.dWdata = '0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1;
        step();
        step();
        reset = 0;
        tests++; if (bus0.pValid !== 1'b0) begin failed++; $display("FAIL rst_pValid got=%0b exp=0", bus0.pValid); end
        tests++; if (bus0.dValid !== 1'b0) begin failed++; $display("FAIL rst_dValid got=%0b exp=0", bus0.dValid); end
        tests++; if (bus0.pRdata !== 32'h0) begin failed++; $display("FAIL rst_pRdata got=%h exp=0", bus0.pRdata); end
        tests++; if (bus0.dRdata !== 32'h0) begin failed++; $display("FAIL rst_dRdata got=%h exp=0", bus0.dRdata); end
        tests++; if (bus0.owner !== 2'b00) begin failed++; $display("FAIL rst_owner got=%b exp=00", bus0.owner); end
    endtask

    task automatic test_p_read();
        bus0.pReq = 1; bus0.pWrite = 0; bus0.pAddr = 5'd22;
        #1;
        tests++; if (bus0.pStall !== 1'b0) begin failed++; $display("FAIL pread_stall got=%0b exp=0", bus0.pStall); end
        tests++; if (bus0.dAck !== 1'b0) begin failed++; $display("FAIL pread_dack got=%0b exp=0", bus0.dAck); end
        step();
        bus0.pReq = 0;
        tests++; if (bus0.pValid !== 1'b1) begin failed++; $display("FAIL pread_valid got=%0b exp=1", bus0.pValid); end
        tests++; if (bus0.pRdata !== 32'd5) begin failed++; $display("FAIL pread_data got=%h exp=5", bus0.pRdata); end
        tests++; if (bus0.dValid !== 1'b0) begin failed++; $display("FAIL pread_dvalid got=%0b exp=0", bus0.dValid); end
        tests++; if (bus0.owner !== 2'b01) begin failed++; $display("FAIL pread_owner got=%b exp=01", bus0.owner); end
        step();
        tests++; if (bus0.pValid !== 1'b0) begin failed++; $display("FAIL pread_pulse got=%0b exp=0", bus0.pValid); end
        tests++; if (bus0.owner !== 2'b00) begin failed++; $display("FAIL pread_idle got=%b exp=00", bus0.owner); end
    endtask

    task automatic test_raw();
        bus0.pReq = 1; bus0.pWrite = 1; bus0.pAddr = 5'd7; bus0.pWdata = 32'hDEADBEEF;
        #1;
        tests++; if (bus0.pStall !== 1'b0) begin failed++; $display("FAIL raw_wstall got=%0b exp=0", bus0.pStall); end
        step();
        bus0.pWrite = 0;
        tests++; if (bus0.pValid !== 1'b0) begin failed++; $display("FAIL raw_wvalid got=%0b exp=0", bus0.pValid); end
        tests++; if (bus0.pStall !== 1'b0) begin failed++; $display("FAIL raw_rstall got=%0b exp=0", bus0.pStall); end
        step();
        bus0.pReq = 0;
        tests++; if (bus0.pValid !== 1'b1) begin failed++; $display("FAIL raw_rvalid got=%0b exp=1", bus0.pValid); end
        tests++; if (bus0.pRdata !== 32'hDEADBEEF) begin failed++; $display("FAIL raw_data got=%h exp=deadbeef", bus0.pRdata); end
        step();
    endtask

    task automatic test_starvation();
        bus0.pReq = 1; bus0.pWrite = 0; bus0.pAddr = 5'd10;
        bus0.dReq = 1; bus0.dWrite = 0; bus0.dAddr = 5'd3;
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests++; if (bus0.dAck !== 1'b0) begin failed++; $display("FAIL starve_dack c%0d got=%0b exp=0", c, bus0.dAck); end
            tests++; if (bus0.pStall !== 1'b0) begin failed++; $display("FAIL starve_stall c%0d got=%0b exp=0", c, bus0.pStall); end
            step();
            tests++; if (bus0.pRdata !== 32'd10) begin failed++; $display("FAIL starve_pdata c%0d got=%h exp=a", c, bus0.pRdata); end
        end
        #1;
        tests++; if (bus0.dAck !== 1'b1) begin failed++; $display("FAIL starve_force_dack got=%0b exp=1", bus0.dAck); end
        tests++; if (bus0.pStall !== 1'b1) begin failed++; $display("FAIL starve_force_stall got=%0b exp=1", bus0.pStall); end
        step();
        bus0.dReq = 0;
        tests++; if (bus0.dValid !== 1'b1) begin failed++; $display("FAIL starve_dvalid got=%0b exp=1", bus0.dValid); end
        tests++; if (bus0.dRdata !== 32'd3) begin failed++; $display("FAIL starve_ddata got=%h exp=3", bus0.dRdata); end
        tests++; if (bus0.owner !== 2'b10) begin failed++; $display("FAIL starve_owner got=%b exp=10", bus0.owner); end
        tests++; if (bus0.pValid !== 1'b0) begin failed++; $display("FAIL starve_pvalid got=%0b exp=0", bus0.pValid); end
        #1;
        tests++; if (bus0.pStall !== 1'b0) begin failed++; $display("FAIL starve_regain got=%0b exp=0", bus0.pStall); end
        step();
        bus0.pReq = 0;
        tests++; if (bus0.owner !== 2'b01) begin failed++; $display("FAIL starve_owner_p got=%b exp=01", bus0.owner); end
        step();
    endtask

    task automatic test_d_write();
        bus0.dReq = 1; bus0.dWrite = 1; bus0.dAddr = 5'd31; bus0.dWdata = 32'h12345678;
        #1;
        tests++; if (bus0.dAck !== 1'b1) begin failed++; $display("FAIL dwr_ack got=%0b exp=1", bus0.dAck); end
        step();
        bus0.dReq = 0; bus0.dWrite = 0;
        tests++; if (bus0.dValid !== 1'b0) begin failed++; $display("FAIL dwr_dvalid got=%0b exp=0", bus0.dValid); end
        tests++; if (bus0.owner !== 2'b10) begin failed++; $display("FAIL dwr_owner got=%b exp=10", bus0.owner); end
        bus0.pReq = 1; bus0.pWrite = 0; bus0.pAddr = 5'd31;
        step();
        bus0.pReq = 0;
        tests++; if (bus0.pRdata !== 32'h12345678) begin failed++; $display("FAIL dwr_pdata got=%h exp=12345678", bus0.pRdata); end
        step();
    endtask

    task automatic test_out_of_range();
        bus1.pReq = 1; bus1.pWrite = 1; bus1.pAddr = 5'd30; bus1.pWdata = 32'hAAAA5555;
        step();
        bus1.pWrite = 0;
        step();
        tests++; if (bus1.pValid !== 1'b1) begin failed++; $display("FAIL oor_valid got=%0b exp=1", bus1.pValid); end
        tests++; if (bus1.pRdata !== 32'h0) begin failed++; $display("FAIL oor_data got=%h exp=0", bus1.pRdata); end
        bus1.pAddr = 5'd22;
        step();
        tests++; if (bus1.pRdata !== 32'd5) begin failed++; $display("FAIL oor_edge22 got=%h exp=5", bus1.pRdata); end
        bus1.pAddr = 5'd23;
        step();
        bus1.pReq = 0;
        tests++; if (bus1.pRdata !== 32'h0) begin failed++; $display("FAIL oor_last23 got=%h exp=0", bus1.pRdata); end
        step();
    endtask

    task automatic test_reset_mid();
        bus0.pReq = 1; bus0.pWrite = 0; bus0.pAddr = 5'd5;
        bus0.dReq = 1; bus0.dWrite = 0; bus0.dAddr = 5'd4;
        step();
        step();
        reset = 1;
        bus0.pWrite = 1; bus0.pWdata = 32'hFFFFFFFF;
        step();
        reset = 0;
        bus0.pWrite = 0;
        tests++; if (bus0.pValid !== 1'b0) begin failed++; $display("FAIL rmid_pvalid got=%0b exp=0", bus0.pValid); end
        tests++; if (bus0.dValid !== 1'b0) begin failed++; $display("FAIL rmid_dvalid got=%0b exp=0", bus0.dValid); end
        tests++; if (bus0.owner !== 2'b00) begin failed++; $display("FAIL rmid_owner got=%b exp=00", bus0.owner); end
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests++; if (bus0.dAck !== 1'b0) begin failed++; $display("FAIL rmid_wait c%0d got=%0b exp=0", c, bus0.dAck); end
            step();
            tests++; if (bus0.pRdata !== 32'd5) begin failed++; $display("FAIL rmid_mem c%0d got=%h exp=5", c, bus0.pRdata); end
        end
        #1;
        tests++; if (bus0.dAck !== 1'b1) begin failed++; $display("FAIL rmid_force got=%0b exp=1", bus0.dAck); end
        step();
        bus0.dReq = 0; bus0.pReq = 0;
        tests++; if (bus0.dRdata !== 32'd4) begin failed++; $display("FAIL rmid_ddata got=%h exp=4", bus0.dRdata); end
        step();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1;
        test_reset();
        test_p_read();
        test_raw();
        test_starvation();
        test_d_write();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Owns the single-port 32-word data memory and shares it between two requesters: the pipeline memory-access stage (P port) and the debug/loader port (D port).
- Serves at most one access per clock.
- P has priority. D is protected from starvation by a wait counter.
- Stalls the pipeline whenever P is denied the memory.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 32, number of memory words; must be ≤ 2^ADDR_W.
- MAX_WAIT, 3, number of consecutive denied cycles after which D is forced ahead of P; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pReq  in  1  pipeline access request; held while pStall=1.
- pWrite  in  1  1 = write, 0 = read.
- pAddr  in  ADDR_W  pipeline word address.
- pWdata  in  DATA_W  pipeline write data.
- pStall  out  1  combinational; P request not granted this cycle.
- pRdata  out  DATA_W  registered read data.
- pValid  out  1  registered; pRdata valid (one cycle after a granted P read).
- dReq  in  1  debug request; held stable until dAck.
- dWrite  in  1  1 = write, 0 = read.
- dAddr  in  ADDR_W  debug word address.
- dWdata  in  DATA_W  debug write data.
- dAck  out  1  combinational; D request granted this cycle.
- dRdata  out  DATA_W  registered read data.
- dValid  out  1  registered; dRdata valid (one cycle after a granted D read).
- owner  out  2  registered last-grant state: 00 IDLE, 01 PIPE, 10 DBG.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous, active-high.
- Reset values: pRdata=0, pValid=0, dRdata=0, dValid=0, owner=IDLE, waitCnt=0.
  - Memory contents are not cleared by reset.
  - Memory initial image: mem[i]=i for i<20; mem[20]=1, mem[21]=2, mem[22]=5; all others 0.
- Grant logic (combinational, same cycle):
  - forceD = dReq && (waitCnt==MAX_WAIT)
  - grantP = pReq && !forceD
  - grantD = dReq && !grantP
  - pStall = pReq && !grantP
  - dAck = grantD
- waitCnt (sequential):
  - dReq && !grantD → increment, saturating at MAX_WAIT.
  - Otherwise → cleared to 0.
- Access:
  - Granted write: mem[addr] ← wdata at the posedge; no valid pulse.
  - Granted read: the requester's rdata ← mem[addr] and valid=1 at the posedge, so data appears one cycle after grant.
  - Valid outputs are single-cycle pulses, cleared on any cycle without a granted read.
  - The non-granted port's rdata holds its previous value.
- Read-after-write:
  - A write at cycle N followed by a read of the same address at cycle N+1 returns the new data. No bypass is needed, because the write completes at the end of cycle N.
- Out of range (addr ≥ DEPTH): writes are ignored; reads return 0 with the valid pulse still asserted.
- owner FSM, next state:
  - grantP → PIPE
  - grantD → DBG
  - no request → IDLE
  - Code 11 is illegal and recovers to IDLE.
- Simultaneous requests:
  - P wins. D is denied up to MAX_WAIT consecutive cycles, then wins exactly one cycle.
  - On that cycle pStall=1; waitCnt then returns to 0.
- Reset mid-operation:
  - Reset has priority over everything. No memory write occurs in a reset cycle, even if requested.
  - Valid outputs are 0 the cycle after reset.
  - Requesters must re-present pending requests.
- Both ports issuing identical addresses has no special handling; accesses are serialised by grant order.

Test Plan:
- Reset, then P read addr 22 → pStall=0; next cycle pValid=1, pRdata=5; dValid=0; owner=PIPE.
- P write addr 7 data 0xDEADBEEF, then P read addr 7 the next cycle → pRdata=0xDEADBEEF one cycle after the read; no stall.
- pReq and dReq both held continuously, D read addr 3, MAX_WAIT=3 → dAck low for 3 cycles with pStall=0. Cycle 4: dAck=1, pStall=1. Next cycle: dValid=1, dRdata=3, owner=DBG. Cycle 5: P regains the grant.
- D-only write addr 31 data 0x12345678, then P read addr 31 → dAck=1 immediately (waitCnt=0); later pRdata=0x12345678.
- DEPTH=24: P write addr 30, then read addr 30 → write ignored; pValid=1, pRdata=0.
- dReq pending with waitCnt=2, assert reset for one cycle with P write requested → memory unchanged, waitCnt=0, all valids 0, owner=IDLE.
